// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and drain FSM states for the conv output path
package conv_pkg;

    localparam int WORD_AMOUNT_O  = 6272;
    localparam int BIT_PER_WORD_O = 16;
    localparam int ADDR_W         = 13;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } drain_state_e;

endpackage

// File: rtl/o_pair_fifo.sv
// rtl/o_pair_fifo.sv - 2-entry FIFO of {O0 word, O1 word} pairs
module o_pair_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_o0,
    input  logic [W-1:0] push_o1,
    input  logic         pop,
    output logic [W-1:0] head_o0,
    output logic [W-1:0] head_o1,
    output logic [1:0]   count
);

    logic [W-1:0] mem_o0 [2];
    logic [W-1:0] mem_o1 [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // storage, pointers and occupancy; push and pop in one cycle leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_o0[0] <= '0;
            mem_o0[1] <= '0;
            mem_o1[0] <= '0;
            mem_o1[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                mem_o0[wr_ptr] <= push_o0;
                mem_o1[wr_ptr] <= push_o1;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_o0 = mem_o0[rd_ptr];
    assign head_o1 = mem_o1[rd_ptr];

    // the issuing side owns flow control; these only catch a broken credit rule
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == 2'd2));
    assert property (@(posedge clk) disable iff (rst) !(pop && count == 2'd0));

endmodule

// File: rtl/o_sram_drain.sv
// rtl/o_sram_drain.sv - streams output banks O0/O1 as a 16-bit valid/ready beat stream
module o_sram_drain
    import conv_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         len,
    output logic [ADDR_W-1:0]         addr_O0,
    output logic [ADDR_W-1:0]         addr_O1,
    output logic                      we_O0,
    output logic                      we_O1,
    input  logic [BIT_PER_WORD_O-1:0] dout_O0,
    input  logic [BIT_PER_WORD_O-1:0] dout_O1,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [BIT_PER_WORD_O-1:0] m_data,
    output logic                      m_bank,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done
);

    localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(WORD_AMOUNT_O);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    drain_state_e              state_q, state_d;
    logic [ADDR_W-1:0]         rd_addr, last_addr, out_idx, addr_q;
    logic [ADDR_W-1:0]         len_eff, start_last, issue_addr;
    logic                      addr_live, data_live, phase;
    logic                      launch, issue, at_last, xfer, pop;
    logic [1:0]                fifo_count;
    logic [2:0]                occ;
    logic [BIT_PER_WORD_O-1:0] head_o0, head_o1;

    assign len_eff    = (len > WORDS) ? WORDS : len;
    assign start_last = len_eff - ONE;

    // The first read (address 0) goes out on the same edge that accepts start,
    // so address 0 is on the SRAM bus in the very next cycle.
    assign launch     = (state_q == IDLE) && start && (len != '0);
    assign issue_addr = launch ? '0 : rd_addr;
    assign at_last    = launch ? (start_last == '0) : (rd_addr == last_addr);

    // Credits: a pair is counted from address-on-bus until its beat B is accepted.
    // A slot released by this cycle's pop is reusable at once; without that the
    // 4-cycle pair lifetime would leave a bubble every other pair.
    assign occ   = 3'(fifo_count) + 3'(addr_live) + 3'(data_live);
    assign xfer  = m_valid && m_ready;
    assign pop   = xfer && phase;
    assign issue = launch ||
                   ((state_q == RUN) && ((occ < 3'd2) || ((occ == 3'd2) && pop)));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; a single-word drain has nothing left to issue and skips RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (start_last == '0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN:     if (issue && at_last) state_d = FLUSH;
            FLUSH:   if (pop && m_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // read issue pipeline and beat sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr   <= '0;
            last_addr <= '0;
            out_idx   <= '0;
            addr_q    <= '0;
            addr_live <= 1'b0;
            data_live <= 1'b0;
            phase     <= 1'b0;
        end else begin
            if (launch) begin
                last_addr <= start_last;
            end
            if (issue) begin
                addr_q  <= issue_addr;
                rd_addr <= at_last ? issue_addr : issue_addr + ONE;
            end
            addr_live <= issue;
            data_live <= addr_live;
            if (launch) begin
                out_idx <= '0;
                phase   <= 1'b0;
            end else if (xfer) begin
                phase <= ~phase;
                if (phase) begin
                    out_idx <= out_idx + ONE;
                end
            end
        end
    end

    o_pair_fifo #(
        .W(BIT_PER_WORD_O)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (data_live),
        .push_o0 (dout_O0),
        .push_o1 (dout_O1),
        .pop     (pop),
        .head_o0 (head_o0),
        .head_o1 (head_o1),
        .count   (fifo_count)
    );

    assign addr_O0 = addr_q;
    assign addr_O1 = addr_q;
    assign we_O0   = 1'b0;
    assign we_O1   = 1'b0;
    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = m_valid ? (phase ? head_o1 : head_o0) : '0;
    assign m_bank  = m_valid && phase;
    assign m_last  = m_valid && phase && (out_idx == last_addr);
    assign busy    = (state_q == RUN) || (state_q == FLUSH);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_o_sram_drain.sv
// tb/tb_o_sram_drain.sv - scoreboard bench for o_sram_drain
module tb_o_sram_drain;
    import conv_pkg::*;

    logic                      clk     = 1'b0;
    logic                      rst     = 1'b1;
    logic                      start   = 1'b0;
    logic [ADDR_W-1:0]         len     = '0;
    logic [ADDR_W-1:0]         addr_O0, addr_O1;
    logic                      we_O0, we_O1;
    logic [BIT_PER_WORD_O-1:0] dout_O0 = '0;
    logic [BIT_PER_WORD_O-1:0] dout_O1 = '0;
    logic                      m_valid;
    logic                      m_ready = 1'b1;
    logic [BIT_PER_WORD_O-1:0] m_data;
    logic                      m_bank, m_last, busy, done;

    logic [BIT_PER_WORD_O-1:0] mem0 [WORD_AMOUNT_O];
    logic [BIT_PER_WORD_O-1:0] mem1 [WORD_AMOUNT_O];
    logic [17:0]               exp_q [$];

    int n_total = 0, n_pass = 0, cyc = 0, ready_mode = 0, inv_err = 0;
    int t0 = 0, first_v = -1, last_x = -1, done_c = -1, maxa = 0, nbeats = 0, a0 = -1;
    bit b0 = 1'b0;

    o_sram_drain dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .addr_O0 (addr_O0),
        .addr_O1 (addr_O1),
        .we_O0   (we_O0),
        .we_O1   (we_O1),
        .dout_O0 (dout_O0),
        .dout_O1 (dout_O1),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_bank  (m_bank),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous SRAM banks with 1-cycle read latency
    always @(posedge clk) begin
        dout_O0 <= mem0[int'(addr_O0) % WORD_AMOUNT_O];
        dout_O1 <= mem1[int'(addr_O1) % WORD_AMOUNT_O];
    end

    // sink readiness: 0 = always ready, 1 = random 50%, 2 = stalled
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    endtask

    // monitor: pops expected beats on every transfer, tracks stall stability
    initial begin
        logic [17:0] prev;
        logic [17:0] got;
        logic [17:0] e;
        bit          have_prev;
        have_prev = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 1'b0;
            end else begin
                got = {m_bank, m_last, m_data};
                if (we_O0 || we_O1 || (addr_O1 != addr_O0)) inv_err++;
                if (have_prev && (!m_valid || got != prev)) inv_err++;
                have_prev = m_valid && !m_ready;
                prev      = got;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'(got), 64'h3ffff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'(got), 64'(e));
                    end
                end
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < WORD_AMOUNT_O; i++) begin
            mem0[i] = 16'($urandom);
            mem1[i] = 16'($urandom);
        end
    endtask

    task automatic launch(input int len_in);
        int L;
        L = (len_in > WORD_AMOUNT_O) ? WORD_AMOUNT_O : len_in;
        for (int i = 0; i < L; i++) begin
            exp_q.push_back({1'b0, 1'b0, mem0[i]});
            exp_q.push_back({1'b1, (i == L - 1), mem1[i]});
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = ADDR_W'(len_in);
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic init_obs();
        first_v = -1;
        last_x  = -1;
        done_c  = -1;
        maxa    = 0;
        nbeats  = 0;
        a0      = -1;
        b0      = 1'b0;
    endtask

    task automatic observe(input int ncyc, input bit stop_done, input bit extra, input int stop_beats);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                last_x = cyc;
                nbeats++;
            end
            if (int'(addr_O0) > maxa) maxa = int'(addr_O0);
            if (done && done_c < 0) done_c = cyc;
            if (cyc == t0) begin
                a0 = int'(addr_O0);
                b0 = busy;
            end
            start = extra && busy && (k % 29 == 3);
            if (start) len = ADDR_W'($urandom_range(1, 8000));
            if (stop_done && done_c >= 0) break;
            if (stop_beats > 0 && nbeats >= stop_beats) break;
        end
        start = 1'b0;
    endtask

    task automatic finish_drain(input string tag, input int L, input int inv0);
        chk({tag, "_done_seen"}, 64'(done_c >= 0), 64'(1));
        chk({tag, "_beats"}, 64'(nbeats), 64'(2 * L));
        chk({tag, "_done_latency"}, 64'(done_c), 64'(last_x + 1));
        chk({tag, "_max_addr"}, 64'(maxa), 64'(L - 1));
        @(negedge clk);
        chk({tag, "_idle_after"}, 64'({done, busy, m_valid}), 64'(0));
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
        chk({tag, "_handshake"}, 64'(inv_err - inv0), 64'(0));
    endtask

    initial begin
        int inv0;
        for (int i = 0; i < WORD_AMOUNT_O; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({m_valid, m_data, m_bank, m_last, busy, done,
                                  addr_O0, addr_O1, we_O0, we_O1}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // fixed pattern, short drain, sink always ready
        for (int i = 0; i < WORD_AMOUNT_O; i++) begin
            mem0[i] = 16'(i);
            mem1[i] = 16'(32768 + i);
        end
        ready_mode = 0;
        inv0 = inv_err;
        launch(4);
        init_obs();
        observe(60, 1'b1, 1'b0, 0);
        chk("t1_first_addr", 64'(a0), 64'(0));
        chk("t1_busy_after_start", 64'(b0), 64'(1));
        chk("t1_first_valid", 64'(first_v), 64'(t0 + 2));
        chk("t1_no_bubbles", 64'(last_x - first_v), 64'(7));
        finish_drain("t1", 4, inv0);

        // full bank, random backpressure
        fill_random();
        ready_mode = 1;
        inv0 = inv_err;
        launch(WORD_AMOUNT_O);
        init_obs();
        observe(40000, 1'b1, 1'b0, 0);
        chk("t2_first_addr", 64'(a0), 64'(0));
        finish_drain("t2", WORD_AMOUNT_O, inv0);

        // stalled sink: at most two pairs outstanding
        ready_mode = 2;
        inv0 = inv_err;
        launch(3);
        init_obs();
        observe(25, 1'b0, 1'b0, 0);
        chk("t3_first_valid", 64'(first_v), 64'(t0 + 2));
        chk("t3_stall_max_addr", 64'(maxa), 64'(1));
        chk("t3_stall_beats", 64'(nbeats), 64'(0));
        ready_mode = 0;
        observe(100, 1'b1, 1'b0, 0);
        finish_drain("t3", 3, inv0);

        // zero-length drain
        launch(0);
        init_obs();
        observe(10, 1'b1, 1'b0, 0);
        chk("t4_done_at_start", 64'(done_c), 64'(t0));
        chk("t4_busy", 64'(b0), 64'(0));
        @(negedge clk);
        chk("t4_after", 64'({done, busy}), 64'(0));
        observe(5, 1'b0, 1'b0, 0);
        chk("t4_no_valid", 64'(first_v), 64'(-1));

        // reset mid-drain, then a fresh short drain
        ready_mode = 1;
        launch(8);
        init_obs();
        observe(200, 1'b0, 1'b0, 5);
        chk("t5_reach_beat5", 64'(nbeats), 64'(5));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t5_reset_outputs", 64'({m_valid, m_data, m_bank, m_last, busy, done,
                                     addr_O0, addr_O1, we_O0, we_O1}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_obs();
        observe(6, 1'b0, 1'b0, 0);
        chk("t5_quiet_after_reset", 64'(first_v), 64'(-1));
        ready_mode = 0;
        inv0 = inv_err;
        launch(2);
        init_obs();
        observe(50, 1'b1, 1'b0, 0);
        finish_drain("t5", 2, inv0);

        // oversized len is clamped; starts while busy are ignored
        fill_random();
        ready_mode = 0;
        inv0 = inv_err;
        launch(7000);
        init_obs();
        observe(14000, 1'b1, 1'b1, 0);
        finish_drain("t6", WORD_AMOUNT_O, inv0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
